// File: rtl/input_debouncer.sv
// input_debouncer
// Multi-channel two-flop synchronizer plus debouncer for slide switches and
// push buttons. Each channel produces a clean level and single-cycle rise and
// fall pulses. A new level is accepted only after the synchronized input has
// disagreed with the clean level for CNT_MAX consecutive cycles. Shorter
// disagreements are discarded as glitches.
// Optional feature: define DEBOUNCE_TOGGLE_EN to add toggle_out. Each bit of
// toggle_out flips on every accepted rising edge, so a push button behaves as
// an on/off latch.
module input_debouncer #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1_000_000,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle_out
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CntTerminal = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync1Q;
  logic [WIDTH-1:0] sync2Q;

  // Two-flop chain that brings the asynchronous pin levels into the clock domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1Q <= '0;
      sync2Q <= '0;
    end else begin
      sync1Q <= raw_in;
      sync2Q <= sync1Q;
    end
  end

  for (genvar ch = 0; ch < WIDTH; ch++) begin : gChannel
    state_e           stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             cleanQ, cleanD;
    logic             riseQ, riseD;
    logic             fallQ, fallD;
    logic             mismatch;
    logic             accept;

    assign mismatch = sync2Q[ch] ^ cleanQ;
    assign accept   = (stateQ == COUNT) && mismatch && (cntQ == CntTerminal);

    // State register tracking whether this channel is timing a candidate level
    always_ff @(posedge clk) begin
      if (reset) stateQ <= IDLE;
      else       stateQ <= stateD;
    end

    // Next state: start timing on disagreement, stop on abort or acceptance
    always_comb begin
      stateD = stateQ;
      unique case (stateQ)
        IDLE:    if (mismatch) stateD = COUNT;
        COUNT:   if (!mismatch || accept) stateD = IDLE;
        default: stateD = IDLE;
      endcase
    end

    // Datapath next values: count while disagreeing, clear on abort, commit on terminal count
    always_comb begin
      cntD   = '0;
      cleanD = cleanQ;
      riseD  = 1'b0;
      fallD  = 1'b0;
      if (accept) begin
        cleanD = sync2Q[ch];
        riseD  = sync2Q[ch];
        fallD  = ~sync2Q[ch];
      end else if (mismatch) begin
        cntD = cntQ + CNT_W'(1);
      end
    end

    // Counter, clean level and pulse registers; outputs come straight from these flops
    always_ff @(posedge clk) begin
      if (reset) begin
        cntQ   <= '0;
        cleanQ <= 1'b0;
        riseQ  <= 1'b0;
        fallQ  <= 1'b0;
      end else begin
        cntQ   <= cntD;
        cleanQ <= cleanD;
        riseQ  <= riseD;
        fallQ  <= fallD;
      end
    end

    assign clean_out[ch]  = cleanQ;
    assign rise_pulse[ch] = riseQ;
    assign fall_pulse[ch] = fallQ;

`ifdef DEBOUNCE_TOGGLE_EN
    logic toggleQ;

    // Latch that flips on every accepted press
    always_ff @(posedge clk) begin
      if (reset)                      toggleQ <= 1'b0;
      else if (accept && sync2Q[ch])  toggleQ <= ~toggleQ;
    end

    assign toggle_out[ch] = toggleQ;
`endif
  end

endmodule
